hsv_ws2812_tx: RTL and testbench

HSV_WS2812_TX -- requirements
Module: hsv_ws2812_tx

---
 rtl/hsv_ws2812_tx.sv | 138 +++++++++++++
 tb/tb_hsv_ws2812_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hsv_ws2812_tx.sv
// WS2812 serial transmitter: takes one 24-bit RGB word per handshake and
// sends it as GRB, MSB first, to NUM_LEDS chained LEDs, then holds the latch low time.
//
// state | meaning
// IDLE  | waiting for a colour, rgb_ready high
// HIGH  | high part of the current bit (T1H or T0H cycles)
// LOW   | low remainder of the current bit, up to TBIT cycles
// LATCH | line held low for TRES cycles, also entered from reset
module hsv_ws2812_tx #(
  parameter int T0H      = 7,
  parameter int T1H      = 14,
  parameter int TBIT     = 25,
  parameter int TRES     = 1000,
  parameter int NUM_LEDS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  output logic        led_out,
  output logic        busy
);

  localparam int CYC_MAX = (TBIT > TRES) ? TBIT : TRES;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam int NBITS   = 24 * NUM_LEDS;
  localparam int BW      = $clog2(NBITS + 1);

  // Terminal counts: each phase ends when the elapsed-cycle counter hits length-1.
  localparam logic [CW-1:0] T0H_LAST  = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_LAST  = CW'(T1H - 1);
  localparam logic [CW-1:0] T0L_LAST  = CW'(TBIT - T0H - 1);
  localparam logic [CW-1:0] T1L_LAST  = CW'(TBIT - T1H - 1);
  localparam logic [CW-1:0] TRES_LAST = CW'(TRES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [4:0]    word_bit, word_bit_nxt;
  logic [23:0]   word, word_nxt;
  logic [23:0]   shreg, shreg_nxt;
  logic          led_nxt;
  logic          cur_bit;
  logic [CW-1:0] high_last, low_last;

  assign cur_bit   = shreg[23];
  assign high_last = cur_bit ? T1H_LAST : T0H_LAST;
  assign low_last  = cur_bit ? T1L_LAST : T0L_LAST;
  assign rgb_ready = (state == IDLE);
  assign busy      = !rgb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LATCH;
      cyc      <= '0;
      bit_cnt  <= '0;
      word_bit <= '0;
      word     <= '0;
      shreg    <= '0;
      led_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      bit_cnt  <= bit_cnt_nxt;
      word_bit <= word_bit_nxt;
      word     <= word_nxt;
      shreg    <= shreg_nxt;
      led_out  <= led_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc + CW'(1);
    bit_cnt_nxt  = bit_cnt;
    word_bit_nxt = word_bit;
    word_nxt     = word;
    shreg_nxt    = shreg;

    case (state)
      IDLE: begin
        cyc_nxt = '0;
        if (rgb_valid) begin
          word_nxt     = {rgb_in[15:8], rgb_in[23:16], rgb_in[7:0]};
          shreg_nxt    = {rgb_in[15:8], rgb_in[23:16], rgb_in[7:0]};
          bit_cnt_nxt  = '0;
          word_bit_nxt = '0;
          state_nxt    = HIGH;
        end
      end
      HIGH: begin
        if (cyc == high_last) begin
          cyc_nxt   = '0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (cyc == low_last) begin
          cyc_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = LATCH;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            state_nxt   = HIGH;
            // Every LED in the chain gets the same word, so reload after 24 bits.
            if (word_bit == 5'd23) begin
              word_bit_nxt = '0;
              shreg_nxt    = word;
            end else begin
              word_bit_nxt = word_bit + 5'd1;
              shreg_nxt    = {shreg[22:0], 1'b0};
            end
          end
        end
      end
      LATCH: begin
        if (cyc == TRES_LAST) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cyc_nxt   = '0;
        state_nxt = LATCH;
      end
    endcase

    // Registered output tracks the state being entered, so the line is high
    // the cycle right after the accepting edge.
    led_nxt = (state_nxt == HIGH);
  end

endmodule

// File: tb/tb_hsv_ws2812_tx.sv
// Self-checking bench for hsv_ws2812_tx: two instances (1 and 3 LEDs) compared
// every cycle against a waveform model computed from bit timing arithmetic.
module tb_hsv_ws2812_tx;
  localparam int T0H  = 7;
  localparam int T1H  = 14;
  localparam int TBIT = 25;
  localparam int TRES = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] rgb_in;
  logic        rgb_valid;
  logic        rdy1, led1, busy1;
  logic        rdy3, led3, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hsv_ws2812_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES), .NUM_LEDS(1)) dut1 (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .rgb_valid(rgb_valid),
    .rgb_ready(rdy1), .led_out(led1), .busy(busy1)
  );

  hsv_ws2812_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES), .NUM_LEDS(3)) dut3 (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .rgb_valid(rgb_valid),
    .rgb_ready(rdy3), .led_out(led3), .busy(busy3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level k cycles after the accepting edge of a frame.
  function automatic logic frame_led(input logic [23:0] w, input int nl, input int k);
    logic [23:0] grb;
    int          b;
    int          ph;
    if (k >= 24 * nl * TBIT) return 1'b0;
    grb = {w[15:8], w[23:16], w[7:0]};
    b   = int'(grb[23 - ((k / TBIT) % 24)]);
    ph  = k % TBIT;
    return (ph < ((b != 0) ? T1H : T0H));
  endfunction

  // Model per instance: busy window length and position inside it.
  bit          m_busy[2]  = '{1'b1, 1'b1};
  bit          m_frame[2] = '{1'b0, 1'b0};
  int          m_pos[2]   = '{0, 0};
  int          m_len[2]   = '{0, 0};
  int          m_nl[2]    = '{1, 3};
  logic [23:0] m_word[2]  = '{24'h0, 24'h0};
  logic        e_led[2]   = '{1'b0, 1'b0};
  bit          checking   = 1'b0;

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d]  = 1'b1;
        m_frame[d] = 1'b0;
        m_pos[d]   = 0;
        m_len[d]   = TRES;
      end else if (!m_busy[d] && rgb_valid) begin
        m_busy[d]  = 1'b1;
        m_frame[d] = 1'b1;
        m_word[d]  = rgb_in;
        m_pos[d]   = 0;
        m_len[d]   = 24 * m_nl[d] * TBIT + TRES;
      end else if (m_busy[d]) begin
        m_pos[d]++;
        if (m_pos[d] == m_len[d]) m_busy[d] = 1'b0;
      end
      e_led[d] = m_busy[d] && m_frame[d] && frame_led(m_word[d], m_nl[d], m_pos[d]);
    end
    if (reset) checking = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check_val("led1",  32'(led1),  32'(e_led[0]));
      check_val("rdy1",  32'(rdy1),  32'(!m_busy[0]));
      check_val("busy1", 32'(busy1), 32'(m_busy[0]));
      check_val("led3",  32'(led3),  32'(e_led[1]));
      check_val("rdy3",  32'(rdy3),  32'(!m_busy[1]));
      check_val("busy3", 32'(busy3), 32'(m_busy[1]));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (rdy1 && rdy3) break;
      @(negedge clk);
    end
    check_val("idle_reached", 32'(rdy1 && rdy3), 32'd1);
  endtask

  task automatic send(input logic [23:0] w);
    @(negedge clk);
    rgb_in    = w;
    rgb_valid = 1'b1;
    @(negedge clk);
    rgb_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rgb_valid = 1'b0;
    rgb_in    = 24'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Power-up latch period with no traffic
    repeat (1100) @(negedge clk);

    send(24'hFF0000);
    wait_idle();
    send(24'h00A5C3);
    wait_idle();

    // Valid toggled with changing data, mostly while busy
    send($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rgb_valid = 1'($urandom_range(0, 1));
      rgb_in    = 24'($urandom);
    end
    rgb_valid = 1'b0;
    wait_idle();

    // Back-to-back frames with valid held high
    @(negedge clk);
    rgb_in    = 24'h010203;
    rgb_valid = 1'b1;
    @(negedge clk);
    rgb_in    = 24'h040506;
    repeat (1700) @(negedge clk);
    rgb_valid = 1'b0;
    wait_idle();

    // Reset inside the high phase of bit 12
    send(24'hFFFFFF);
    repeat (301) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (1100) @(negedge clk);
    wait_idle();
    send($urandom);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
